// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin scheduler sharing one subtract-based GCD datapath among NREQ
// requesters. Arbitrates, steers the granted requester's operands into the datapath,
// sequences the load/compare/subtract loop from the datapath flags, and returns the result
// and an error flag to the granted requester.
//
// Optional feature macro: GCD_ZERO_CHECK_EN
//   defined   - a zero operand is detected in LOAD_A; the job skips the datapath and returns
//               op_a|op_b with err=0.
//   undefined - zero operands run through the datapath (gcd(0,x) times out with err=1).
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req[NREQ]           per-requester level request, held until own done
//   op_a, op_b          packed operands, slice i belongs to requester i
//   gnt[NREQ]           registered one-hot grant, zero when idle
//   done[NREQ]          one-cycle completion pulse to the granted requester
//   result, err         registered GCD and timeout/error flag, qualified by done
//   data_in             operand mux to the datapath
//   ldA, ldB, sel1,
//   sel2, sel_in        datapath controls
//   lt, gt, eq, dp_a    datapath comparator flags and A register value
module gcd_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MAX_ITER = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] op_a,
  input  logic [NREQ*WIDTH-1:0] op_b,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      result,
  output logic                  err,
  output logic [WIDTH-1:0]      data_in,
  output logic                  ldA,
  output logic                  ldB,
  output logic                  sel1,
  output logic                  sel2,
  output logic                  sel_in,
  input  logic                  lt,
  input  logic                  gt,
  input  logic                  eq,
  input  logic [WIDTH-1:0]      dp_a
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(MAX_ITER + 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoadA = 3'd1;
  localparam logic [2:0] StLoadB = 3'd2;
  localparam logic [2:0] StCmp   = 3'd3;
  localparam logic [2:0] StWait  = 3'd4;
  localparam logic [2:0] StResp  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [PW-1:0]    idx_q, idx_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;

  logic [PW-1:0]    pick;
  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];
  logic [WIDTH-1:0] cur_a, cur_b;

  // Unpack operand buses so the granted slice can be selected by index.
  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      a_arr[i] = op_a[i*WIDTH +: WIDTH];
      b_arr[i] = op_b[i*WIDTH +: WIDTH];
    end
  end

  assign cur_a = a_arr[idx_q];
  assign cur_b = b_arr[idx_q];

  // Round-robin pick: the requester with the smallest distance upward from ptr wins.
  always_comb begin
    int best;
    int off;
    best = int'(NREQ);
    off  = 0;
    pick = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (req[k]) begin
        off = (k + int'(NREQ) - int'(ptr_q)) % int'(NREQ);
        if (off < best) begin
          best = off;
          pick = PW'(k);
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    data_in  = '0;
    ldA      = 1'b0;
    ldB      = 1'b0;
    sel1     = 1'b0;
    sel2     = 1'b0;
    sel_in   = 1'b0;
    done     = '0;

    case (state_q)
      StIdle: begin
        if (|req) begin
          gnt_d   = NREQ'(1) << pick;
          idx_d   = pick;
          cnt_d   = '0;
          state_d = StLoadA;
        end
      end
      StLoadA: begin
        sel_in  = 1'b1;
        data_in = cur_a;
`ifdef GCD_ZERO_CHECK_EN
        if ((cur_a == '0) || (cur_b == '0)) begin
          // gcd(0,x) = x, gcd(0,0) = 0: answer directly without touching the datapath.
          result_d = cur_a | cur_b;
          err_d    = 1'b0;
          state_d  = StResp;
        end else begin
          ldA     = 1'b1;
          state_d = StLoadB;
        end
`else
        ldA     = 1'b1;
        state_d = StLoadB;
`endif
      end
      StLoadB: begin
        sel_in  = 1'b1;
        ldB     = 1'b1;
        data_in = cur_b;
        state_d = StCmp;
      end
      StCmp: begin
        if (eq) begin
          result_d = dp_a;
          err_d    = 1'b0;
          state_d  = StResp;
        end else if (cnt_q == CW'(MAX_ITER)) begin
          result_d = dp_a;
          err_d    = 1'b1;
          state_d  = StResp;
        end else if (lt) begin
          sel1    = 1'b1;
          ldB     = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          state_d = StWait;
        end else if (gt) begin
          sel2    = 1'b1;
          ldA     = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        // Datapath settle cycle before the flags are trusted again.
        state_d = StCmp;
      end
      StResp: begin
        done    = gnt_q;
        ptr_d   = (idx_q == PW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
        gnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign gnt    = gnt_q;
  assign result = result_q;
  assign err    = err_q;

endmodule
